// File: rtl/dma_mc_ctrl.sv
// Multi-channel DMA controller: per-channel descriptor register file, round-robin
// burst arbiter driving one shared address/valid beat stream, per-channel completion irqs.
module dma_mc_ctrl #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int BURST    = 4
) (
    input  logic                        clk,
    input  logic                        arst_n,
    input  logic [WIDTH-1:0]            ctrl_data,
    input  logic [WIDTH-1:0]            ctrl_addr,
    input  logic                        ctrl_WR_en,
    input  logic                        ctrl_RD_en,
    input  logic                        bus_ready,
    output logic [WIDTH-1:0]            dma_txAdrr_out,
    output logic [WIDTH-1:0]            dma_rxAdrr_out,
    output logic                        Valid,
    output logic [$clog2(CHANNELS)-1:0] dma_ch,
    output logic                        dma_busy,
    output logic [WIDTH-1:0]            Rdata,
    output logic [CHANNELS-1:0]         irq_vec,
    output logic                        Interupt
);
    localparam int CW = $clog2(CHANNELS);
    localparam int BW = $clog2(BURST + 1);
    localparam logic [WIDTH-1:0] ADDR_BUSY = '1;
    localparam logic [WIDTH-1:0] ADDR_IRQ  = {{(WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t              state_q;
    logic [WIDTH-1:0]    src_q [CHANNELS];
    logic [WIDTH-1:0]    dst_q [CHANNELS];
    logic [WIDTH-1:0]    len_q [CHANNELS];
    logic [CHANNELS-1:0] irq_en_q, pend_q, irqp_q;
    logic [CHANNELS-1:0] pend_d, irqp_d;
    logic [CW-1:0]       ch_q, ptr_q, arb_ch;
    logic [BW-1:0]       beat_q;
    logic                valid_q;
    logic [WIDTH-1:0]    tx_q, rx_q, rdata_q, rd_val;

    logic                ch_hit, wr_irq, xfer_fire;
    logic [1:0]          reg_sel;
    logic [CW-1:0]       ch_sel;
    logic [CHANNELS-1:0] wr_ch, active_vec, busy_vec, start_go, start_pend, start_zero;
    logic [CHANNELS-1:0] done_set, w1c;

    assign ch_hit    = (ctrl_addr >> (CW + 2)) == '0;
    assign reg_sel   = ctrl_addr[1:0];
    assign ch_sel    = ctrl_addr[CW+1:2];
    assign wr_irq    = ctrl_WR_en && (ctrl_addr == ADDR_IRQ);
    assign xfer_fire = (state_q == XFER) && bus_ready;

    // A channel is locked against descriptor writes from START until its DONE cycle ends.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            assign wr_ch[gi]      = ctrl_WR_en && ch_hit && (ch_sel == CW'(gi));
            assign active_vec[gi] = (state_q != IDLE) && (ch_q == CW'(gi));
            assign start_go[gi]   = wr_ch[gi] && (reg_sel == 2'd3) && ctrl_data[0] && !busy_vec[gi];
            assign start_pend[gi] = start_go[gi] && (len_q[gi] != '0);
            assign start_zero[gi] = start_go[gi] && (len_q[gi] == '0);
            assign done_set[gi]   = (state_q == DONE) && (ch_q == CW'(gi));
            if (gi < WIDTH) begin : g_w1c
                assign w1c[gi] = wr_irq && ctrl_data[gi];
            end else begin : g_now1c
                assign w1c[gi] = 1'b0;
            end
        end
    endgenerate

    assign busy_vec = pend_q | active_vec;
    assign pend_d   = (pend_q | start_pend) & ~done_set;
    assign irqp_d   = (irqp_q & ~w1c) | start_zero | done_set;

    always_comb begin
        arb_ch = ptr_q;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pend_q[ptr_q + CW'(i)]) arb_ch = ptr_q + CW'(i);
        end
    end

    always_comb begin
        rd_val = '0;
        if (ch_hit) begin
            case (reg_sel)
                2'd0:    rd_val = src_q[ch_sel];
                2'd1:    rd_val = dst_q[ch_sel];
                2'd2:    rd_val = len_q[ch_sel];
                default: rd_val = WIDTH'({irq_en_q[ch_sel], 1'b0});
            endcase
        end else if (ctrl_addr == ADDR_BUSY) begin
            rd_val = WIDTH'(busy_vec);
        end else if (ctrl_addr == ADDR_IRQ) begin
            rd_val = WIDTH'(irqp_q);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                src_q[c] <= '0;
                dst_q[c] <= '0;
                len_q[c] <= '0;
            end
            irq_en_q <= '0;
            pend_q   <= '0;
            irqp_q   <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (xfer_fire && (ch_q == CW'(c))) begin
                    src_q[c] <= src_q[c] + WIDTH'(1);
                    dst_q[c] <= dst_q[c] + WIDTH'(1);
                    len_q[c] <= len_q[c] - WIDTH'(1);
                end else if (wr_ch[c] && !busy_vec[c]) begin
                    case (reg_sel)
                        2'd0:    src_q[c] <= ctrl_data;
                        2'd1:    dst_q[c] <= ctrl_data;
                        2'd2:    len_q[c] <= ctrl_data;
                        default: ;
                    endcase
                end
                if (wr_ch[c] && (reg_sel == 2'd3)) irq_en_q[c] <= ctrl_data[1];
            end
            pend_q <= pend_d;
            irqp_q <= irqp_d;
        end
    end

    // Address outputs track the live descriptor while Valid, and freeze on the final beat.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            ptr_q   <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pend_q) begin
                        ch_q    <= arb_ch;
                        beat_q  <= '0;
                        valid_q <= 1'b1;
                        tx_q    <= src_q[arb_ch];
                        rx_q    <= dst_q[arb_ch];
                        state_q <= XFER;
                    end
                end
                XFER: begin
                    if (bus_ready) begin
                        beat_q <= beat_q + BW'(1);
                        if (len_q[ch_q] == WIDTH'(1)) begin
                            valid_q <= 1'b0;
                            state_q <= DONE;
                        end else if (beat_q == BW'(BURST - 1)) begin
                            valid_q <= 1'b0;
                            ptr_q   <= ch_q + CW'(1);
                            state_q <= IDLE;
                        end else begin
                            tx_q <= src_q[ch_q] + WIDTH'(1);
                            rx_q <= dst_q[ch_q] + WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    ptr_q   <= ch_q + CW'(1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)         rdata_q <= '0;
        else if (ctrl_RD_en) rdata_q <= rd_val;
    end

    assign dma_txAdrr_out = tx_q;
    assign dma_rxAdrr_out = rx_q;
    assign Valid          = valid_q;
    assign dma_ch         = ch_q;
    assign dma_busy       = |busy_vec;
    assign Rdata          = rdata_q;
    assign irq_vec        = irqp_q & irq_en_q;
    assign Interupt       = |irq_vec;
endmodule

// File: tb/tb_dma_mc_ctrl.sv
// Bench for dma_mc_ctrl: randomized descriptors checked against a round-robin
// transfer model that predicts the beat sequence, irq order and final registers.
module tb_dma_mc_ctrl;
    localparam int CH = 4;
    localparam int BURST = 4;
    localparam int A_IRQ = 254;
    localparam int A_BUSY = 255;

    logic       clk = 1'b0;
    logic       arst_n;
    logic [7:0] ctrl_data, ctrl_addr;
    logic       ctrl_WR_en, ctrl_RD_en, bus_ready;
    logic [7:0] dma_txAdrr_out, dma_rxAdrr_out, Rdata;
    logic       Valid, dma_busy, Interupt;
    logic [1:0] dma_ch;
    logic [3:0] irq_vec;

    dma_mc_ctrl #(.WIDTH(8), .CHANNELS(CH), .BURST(BURST)) dut (
        .clk(clk), .arst_n(arst_n), .ctrl_data(ctrl_data), .ctrl_addr(ctrl_addr),
        .ctrl_WR_en(ctrl_WR_en), .ctrl_RD_en(ctrl_RD_en), .bus_ready(bus_ready),
        .dma_txAdrr_out(dma_txAdrr_out), .dma_rxAdrr_out(dma_rxAdrr_out), .Valid(Valid),
        .dma_ch(dma_ch), .dma_busy(dma_busy), .Rdata(Rdata), .irq_vec(irq_vec),
        .Interupt(Interupt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {int ch; int s; int d;} beat_t;
    beat_t obs[$];
    beat_t expq[$];
    int    obs_irq[$];
    int    exp_irq[$];

    int       m_src[CH];
    int       m_dst[CH];
    int       m_len[CH];
    bit       m_en[CH];
    bit [3:0] m_irq;
    int       m_ptr;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_src[c] = 0; m_dst[c] = 0; m_len[c] = 0; m_en[c] = 0;
        end
        m_irq = '0;
        m_ptr = 0;
    endtask

    // Transfer as a whole: every started channel gets min(BURST, remaining)
    // beats per turn, turns taken in rotation starting from the pointer.
    task automatic model_run(input bit [3:0] set);
        bit [3:0] p;
        int c, n;
        beat_t b;
        p = set;
        while (p != 0) begin
            c = -1;
            for (int k = 0; k < CH; k++)
                if (c < 0 && p[(m_ptr + k) % CH]) c = (m_ptr + k) % CH;
            n = (m_len[c] < BURST) ? m_len[c] : BURST;
            for (int j = 0; j < n; j++) begin
                b.ch = c; b.s = (m_src[c] + j) % 256; b.d = (m_dst[c] + j) % 256;
                expq.push_back(b);
            end
            m_src[c] = (m_src[c] + n) % 256;
            m_dst[c] = (m_dst[c] + n) % 256;
            m_len[c] = m_len[c] - n;
            m_ptr = (c + 1) % CH;
            if (m_len[c] == 0) begin
                p[c] = 1'b0;
                if (m_en[c] && !m_irq[c]) exp_irq.push_back(c);
                m_irq[c] = 1'b1;
            end
        end
    endtask

    function automatic logic [3:0] en_vec();
        logic [3:0] v;
        for (int c = 0; c < CH; c++) v[c] = m_en[c];
        return v;
    endfunction

    task automatic wr(input int a, input int d);
        @(negedge clk);
        ctrl_addr = a[7:0]; ctrl_data = d[7:0]; ctrl_WR_en = 1'b1;
        @(negedge clk);
        ctrl_WR_en = 1'b0;
    endtask

    task automatic rd(input int a, output int d);
        @(negedge clk);
        ctrl_addr = a[7:0]; ctrl_RD_en = 1'b1;
        @(negedge clk);
        ctrl_RD_en = 1'b0;
        d = int'(Rdata);
    endtask

    task automatic cfg(input int c, input int s, input int d, input int l, input bit en);
        wr(4*c, s); wr(4*c + 1, d); wr(4*c + 2, l); wr(4*c + 3, en ? 2 : 0);
        m_src[c] = s; m_dst[c] = d; m_len[c] = l; m_en[c] = en;
    endtask

    // Started in rotation order from the pointer so the first grant is unambiguous.
    task automatic start_set(input bit [3:0] set);
        int c;
        for (int k = 0; k < CH; k++) begin
            c = (m_ptr + k) % CH;
            if (set[c]) wr(4*c + 3, m_en[c] ? 3 : 1);
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!Valid && n < 20) begin @(negedge clk); n++; end
        tests++;
        if (!Valid) begin fails++; $display("FAIL %s wait_valid: Valid=%0b required 1", name, Valid); end
    endtask

    task automatic run_beats(input string name, input int budget, input bit rnd);
        int cyc = 0;
        logic pv = 1'b0, pr = 1'b1;
        logic [7:0] pt = '0, prx = '0;
        logic [1:0] pc = '0;
        logic [3:0] pirq = irq_vec;
        beat_t b;
        forever begin
            @(negedge clk);
            cyc++;
            for (int c = 0; c < CH; c++) if (irq_vec[c] && !pirq[c]) obs_irq.push_back(c);
            pirq = irq_vec;
            if (pv && !pr) begin
                tests++;
                if (!(Valid && dma_txAdrr_out == pt && dma_rxAdrr_out == prx && dma_ch == pc)) begin
                    fails++;
                    $display("FAIL %s hold: valid=%0b tx=%02h rx=%02h ch=%0d required 1 %02h %02h %0d",
                             name, Valid, dma_txAdrr_out, dma_rxAdrr_out, dma_ch, pt, prx, pc);
                end
            end
            if (!dma_busy && !Valid) break;
            if (cyc > budget) begin
                tests++; fails++;
                $display("FAIL %s timeout: busy=%0b after %0d cycles required 0", name, dma_busy, cyc);
                break;
            end
            bus_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (Valid && bus_ready) begin
                b.ch = int'(dma_ch); b.s = int'(dma_txAdrr_out); b.d = int'(dma_rxAdrr_out);
                obs.push_back(b);
            end
            pv = Valid; pr = bus_ready; pt = dma_txAdrr_out; prx = dma_rxAdrr_out; pc = dma_ch;
        end
        bus_ready = 1'b0;
    endtask

    task automatic check_xfer(input string name);
        int v, n;
        tests++;
        if (obs.size() != expq.size()) begin
            fails++;
            $display("FAIL %s beat_count: got %0d required %0d", name, obs.size(), expq.size());
        end
        n = (obs.size() < expq.size()) ? obs.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            tests++;
            if (obs[i].ch !== expq[i].ch || obs[i].s !== expq[i].s || obs[i].d !== expq[i].d) begin
                fails++;
                $display("FAIL %s beat%0d: ch=%0d src=%02h dst=%02h required ch=%0d src=%02h dst=%02h",
                         name, i, obs[i].ch, obs[i].s, obs[i].d, expq[i].ch, expq[i].s, expq[i].d);
            end else begin
                $display("[TB] %s beat %0d ch=%0d src=%02h dst=%02h", name, i, obs[i].ch, obs[i].s, obs[i].d);
            end
        end
        tests++;
        if (obs_irq.size() != exp_irq.size()) begin
            fails++;
            $display("FAIL %s irq_count: got %0d required %0d", name, obs_irq.size(), exp_irq.size());
        end else begin
            for (int i = 0; i < obs_irq.size(); i++) begin
                tests++;
                if (obs_irq[i] !== exp_irq[i]) begin
                    fails++;
                    $display("FAIL %s irq_order%0d: got ch%0d required ch%0d", name, i, obs_irq[i], exp_irq[i]);
                end
            end
        end
        rd(A_IRQ, v);
        tests++;
        if (v !== int'(m_irq)) begin fails++; $display("FAIL %s irq_reg: got %02h required %02h", name, v, m_irq); end
        rd(A_BUSY, v);
        tests++;
        if (v !== 0) begin fails++; $display("FAIL %s busy_reg: got %02h required 00", name, v); end
        for (int c = 0; c < CH; c++) begin
            rd(4*c, v);
            tests++;
            if (v !== m_src[c]) begin fails++; $display("FAIL %s src%0d: got %02h required %02h", name, c, v, m_src[c]); end
            rd(4*c + 1, v);
            tests++;
            if (v !== m_dst[c]) begin fails++; $display("FAIL %s dst%0d: got %02h required %02h", name, c, v, m_dst[c]); end
            rd(4*c + 2, v);
            tests++;
            if (v !== m_len[c]) begin fails++; $display("FAIL %s len%0d: got %02h required %02h", name, c, v, m_len[c]); end
        end
        tests++;
        if (irq_vec !== (m_irq & en_vec()) || Interupt !== |(m_irq & en_vec())) begin
            fails++;
            $display("FAIL %s irq_vec: got %b/%0b required %b", name, irq_vec, Interupt, m_irq & en_vec());
        end
        obs.delete(); expq.delete(); obs_irq.delete(); exp_irq.delete();
    endtask

    task automatic clear_irq(input int mask);
        int v;
        bit [3:0] mk;
        mk = mask[3:0];
        wr(A_IRQ, mask);
        m_irq = m_irq & ~mk;
        rd(A_IRQ, v);
        tests++;
        if (v !== int'(m_irq) || Interupt !== |(m_irq & en_vec())) begin
            fails++;
            $display("FAIL clear_irq: reg=%02h int=%0b required %02h %0b", v, Interupt, m_irq, |(m_irq & en_vec()));
        end
    endtask

    task automatic test_reset();
        int v;
        tests++;
        if ({Valid, dma_busy, Interupt, irq_vec, dma_ch, Rdata, dma_txAdrr_out, dma_rxAdrr_out} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: valid=%0b busy=%0b int=%0b irq=%b ch=%0d rdata=%02h tx=%02h rx=%02h required all 0",
                     Valid, dma_busy, Interupt, irq_vec, dma_ch, Rdata, dma_txAdrr_out, dma_rxAdrr_out);
        end
        foreach (m_src[c]) begin
            rd(4*c + 2, v);
            tests++;
            if (v !== 0) begin fails++; $display("FAIL reset_len%0d: got %02h required 00", c, v); end
        end
        rd(A_BUSY, v);
        tests++;
        if (v !== 0) begin fails++; $display("FAIL reset_busy: got %02h required 00", v); end
        rd(A_IRQ, v);
        tests++;
        if (v !== 0) begin fails++; $display("FAIL reset_irq: got %02h required 00", v); end
    endtask

    task automatic test_single();
        cfg(0, 8'h10, 8'h80, 3, 1'b1);
        bus_ready = 1'b0;
        start_set(4'b0001);
        model_run(4'b0001);
        tests++;
        if (Valid !== 1'b0 || dma_busy !== 1'b1) begin
            fails++; $display("FAIL single_pending: valid=%0b busy=%0b required 0 1", Valid, dma_busy);
        end
        @(negedge clk);
        tests++;
        if (Valid !== 1'b1 || dma_txAdrr_out !== 8'h10 || dma_rxAdrr_out !== 8'h80 || dma_ch !== 2'd0) begin
            fails++;
            $display("FAIL single_grant: valid=%0b tx=%02h rx=%02h ch=%0d required 1 10 80 0",
                     Valid, dma_txAdrr_out, dma_rxAdrr_out, dma_ch);
        end
        run_beats("single", 100, 1'b0);
        check_xfer("single");
        clear_irq(1);
    endtask

    task automatic test_backpressure();
        logic [7:0] t, r;
        cfg(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 2, 1'b1);
        bus_ready = 1'b0;
        start_set(4'b0010);
        model_run(4'b0010);
        wait_valid("backpressure");
        t = dma_txAdrr_out; r = dma_rxAdrr_out;
        repeat (2) begin
            @(negedge clk);
            tests++;
            if (Valid !== 1'b1 || dma_txAdrr_out !== t || dma_rxAdrr_out !== r || dma_ch !== 2'd1) begin
                fails++;
                $display("FAIL backpressure_hold: valid=%0b tx=%02h rx=%02h ch=%0d required 1 %02h %02h 1",
                         Valid, dma_txAdrr_out, dma_rxAdrr_out, dma_ch, t, r);
            end
        end
        run_beats("backpressure", 100, 1'b0);
        check_xfer("backpressure");
        clear_irq(2);
    endtask

    task automatic test_round_robin();
        cfg(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 6, 1'b1);
        cfg(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 5, 1'b1);
        bus_ready = 1'b0;
        start_set(4'b0011);
        model_run(4'b0011);
        run_beats("round_robin", 300, 1'b0);
        check_xfer("round_robin");
        clear_irq(3);
    endtask

    task automatic test_len_zero();
        int v;
        cfg(2, 8'h33, 8'h44, 0, 1'b1);
        bus_ready = 1'b0;
        wr(11, 3);
        m_irq[2] = 1'b1;
        tests++;
        if (irq_vec[2] !== 1'b1 || Valid !== 1'b0 || dma_busy !== 1'b0) begin
            fails++;
            $display("FAIL len_zero_irq: irq2=%0b valid=%0b busy=%0b required 1 0 0", irq_vec[2], Valid, dma_busy);
        end
        repeat (3) begin
            @(negedge clk);
            tests++;
            if (Valid !== 1'b0 || dma_busy !== 1'b0) begin
                fails++; $display("FAIL len_zero_idle: valid=%0b busy=%0b required 0 0", Valid, dma_busy);
            end
        end
        rd(A_IRQ, v);
        tests++;
        if (v !== int'(m_irq)) begin fails++; $display("FAIL len_zero_reg: got %02h required %02h", v, m_irq); end
        clear_irq(4);
    endtask

    task automatic test_wrap();
        cfg(3, 8'hFF, 8'hFE, 2, 1'b0);
        bus_ready = 1'b0;
        start_set(4'b1000);
        model_run(4'b1000);
        run_beats("wrap", 100, 1'b0);
        tests++;
        if (obs.size() != 2 || obs[0].s !== 8'hFF || obs[1].s !== 8'h00) begin
            fails++; $display("FAIL wrap_src: beats=%0d required 2 with src ff then 00", obs.size());
        end
        check_xfer("wrap");
        clear_irq(8);
    endtask

    task automatic test_active_write();
        int v, s0;
        beat_t b;
        s0 = int'($urandom_range(0, 255));
        cfg(3, s0, int'($urandom_range(0, 255)), 5, 1'b1);
        bus_ready = 1'b0;
        start_set(4'b1000);
        model_run(4'b1000);
        wait_valid("active_write");
        bus_ready = 1'b1;
        repeat (2) begin
            b.ch = int'(dma_ch); b.s = int'(dma_txAdrr_out); b.d = int'(dma_rxAdrr_out);
            obs.push_back(b);
            @(negedge clk);
        end
        bus_ready = 1'b0;
        wr(12, 8'h55);
        wr(14, 8'h01);
        rd(12, v);
        tests++;
        if (v !== (s0 + 2) % 256) begin fails++; $display("FAIL active_src: got %02h required %02h", v, (s0 + 2) % 256); end
        rd(14, v);
        tests++;
        if (v !== 3) begin fails++; $display("FAIL active_len: got %02h required 03", v); end
        run_beats("active_write", 100, 1'b0);
        check_xfer("active_write");
        clear_irq(8);
    endtask

    task automatic test_random();
        bit [3:0] set;
        for (int it = 0; it < 6; it++) begin
            set = 4'($urandom_range(1, 15));
            for (int c = 0; c < CH; c++)
                if (set[c]) cfg(c, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                                int'($urandom_range(1, 9)), 1'($urandom_range(0, 1)));
            bus_ready = 1'b0;
            start_set(set);
            model_run(set);
            run_beats("random", 2000, 1'b1);
            check_xfer("random");
            clear_irq(15);
        end
    endtask

    task automatic test_reset_mid();
        int v;
        cfg(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 5, 1'b1);
        bus_ready = 1'b0;
        start_set(4'b0001);
        wait_valid("reset_mid");
        bus_ready = 1'b1;
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        tests++;
        if ({Valid, dma_busy, Interupt, irq_vec, dma_ch, Rdata, dma_txAdrr_out, dma_rxAdrr_out} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: valid=%0b busy=%0b int=%0b irq=%b ch=%0d rdata=%02h tx=%02h rx=%02h required all 0",
                     Valid, dma_busy, Interupt, irq_vec, dma_ch, Rdata, dma_txAdrr_out, dma_rxAdrr_out);
        end
        bus_ready = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        model_reset();
        rd(A_BUSY, v);
        tests++;
        if (v !== 0) begin fails++; $display("FAIL reset_mid_busy: got %02h required 00", v); end
        rd(A_IRQ, v);
        tests++;
        if (v !== 0) begin fails++; $display("FAIL reset_mid_irq: got %02h required 00", v); end
        rd(0, v);
        tests++;
        if (v !== 0) begin fails++; $display("FAIL reset_mid_src: got %02h required 00", v); end
    endtask

    initial begin
        ctrl_data = '0; ctrl_addr = '0; ctrl_WR_en = 1'b0; ctrl_RD_en = 1'b0;
        bus_ready = 1'b0; arst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        test_reset();
        test_single();
        test_backpressure();
        test_round_robin();
        test_len_zero();
        test_wrap();
        test_active_write();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
